// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the UART receive path feeding the AES core.
package aes_uart_pkg;

  typedef enum logic {FILL, FULL} asm_state_t;

  localparam int AES_BLOCK_BYTES   = 16;
  localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_block_assembler_if.sv
// Byte-in / block-out bundle between the UART receiver, the assembler and the AES core.
interface uart_block_assembler_if
  import aes_uart_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES
);

  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic [8*NBYTES-1:0]           block_out;
  logic                          block_valid;
  logic                          block_ready;
  logic [$clog2(NBYTES+1)-1:0]   byte_count;
  logic                          overrun;
  logic                          timeout;
  logic                          err_clr;

  modport master (
    output rx_data, rx_valid, block_ready, err_clr,
    input  block_out, block_valid, byte_count, overrun, timeout
  );

  modport slave (
    input  rx_data, rx_valid, block_ready, err_clr,
    output block_out, block_valid, byte_count, overrun, timeout
  );

endinterface

// File: rtl/uart_edge_strobe.sv
// Turns a level-style valid into a single-cycle strobe on its rising edge.
module uart_edge_strobe #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic strobe_o
);

  logic valid_q;

  // Resetting to 1 hides a valid that is already high when reset releases.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= RESET_VAL;
    end else begin
      valid_q <= valid_i;
    end
  end

  assign strobe_o = valid_i & ~valid_q;

endmodule

// File: rtl/uart_block_assembler.sv
// Packs NBYTES received UART bytes into one block with valid/ready, overrun and idle timeout.
module uart_block_assembler
  import aes_uart_pkg::*;
#(
  parameter int NBYTES         = AES_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                    clk,
  input logic                    rst,
  uart_block_assembler_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW    = 8 * NBYTES;
  localparam int CW    = $clog2(NBYTES + 1);

  asm_state_t       state_q;
  logic [BW-1:0]    block_q;
  logic [BW-1:0]    block_d;
  logic [CW-1:0]    count_q;
  logic [TMO_W-1:0] idle_q;
  logic             valid_q;
  logic             overrun_q;
  logic             overrun_set;
  logic             timeout_q;
  logic             byte_stb;

  uart_edge_strobe #(
    .RESET_VAL (1'b1)
  ) u_edge_strobe (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (bus.rx_valid),
    .strobe_o (byte_stb)
  );

  assign block_d     = (block_q << 8) | BW'(bus.rx_data);
  assign overrun_set = (state_q == FULL) && byte_stb && !bus.block_ready;

  // A handshake and a new byte in the same cycle start the next block instead of overrunning.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      block_q   <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (byte_stb) begin
            block_q <= block_d;
            count_q <= count_q + CW'(1);
            idle_q  <= '0;
            if (count_q == CW'(NBYTES - 1)) begin
              state_q <= FULL;
              valid_q <= 1'b1;
            end
          end else if (count_q != '0) begin
            if (idle_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              count_q   <= '0;
              idle_q    <= '0;
              timeout_q <= 1'b1;
            end else begin
              idle_q <= idle_q + TMO_W'(1);
            end
          end
        end
        FULL: begin
          if (bus.block_ready) begin
            state_q <= FILL;
            valid_q <= 1'b0;
            if (byte_stb) begin
              block_q <= block_d;
              count_q <= CW'(1);
            end else begin
              count_q <= '0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
      overrun_q <= overrun_set | (overrun_q & ~bus.err_clr);
    end
  end

  assign bus.block_out   = block_q;
  assign bus.block_valid = valid_q;
  assign bus.byte_count  = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Self-checking bench: directed scenarios plus random byte traffic against a queue-based model.
module tb_uart_block_assembler;
  import aes_uart_pkg::*;

  localparam int NB  = AES_BLOCK_BYTES;
  localparam int TMO = 50;
  localparam int BW  = 8 * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passCount = 0;
  int   checkCount = 0;
  int   cycleCnt = 0;
  int   riseCnt = 0;

  uart_block_assembler_if #(.NBYTES(NB)) bus ();

  uart_block_assembler #(
    .NBYTES         (NB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Model: stored bytes kept as a history queue; block_out is simply the last NB stored bytes.
  logic [7:0] hist[$];
  logic       mPrev = 1'b1;
  logic       mFull = 1'b0;
  logic       mOv = 1'b0;
  logic       mTmo = 1'b0;
  int         mCount = 0;
  int         mIdle = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] modelBlock();
    logic [BW-1:0] r = '0;
    foreach (hist[i]) r = (r << 8) | BW'(hist[i]);
    return r;
  endfunction

  task automatic storeByte(input logic [7:0] b);
    hist.push_back(b);
    if (hist.size() > NB) void'(hist.pop_front());
    mCount++;
    mIdle = 0;
  endtask

  task automatic modelStep();
    logic stb;
    logic setOv;
    if (!rst) begin
      mPrev = 1'b1; mFull = 1'b0; mOv = 1'b0; mTmo = 1'b0;
      mCount = 0; mIdle = 0;
      hist.delete();
      return;
    end
    stb   = bus.rx_valid && !mPrev;
    mPrev = bus.rx_valid;
    mTmo  = 1'b0;
    setOv = 1'b0;
    if (mFull) begin
      if (bus.block_ready) begin
        mFull  = 1'b0;
        mCount = 0;
        if (stb) storeByte(bus.rx_data);
      end else if (stb) begin
        setOv = 1'b1;
      end
    end else if (stb) begin
      storeByte(bus.rx_data);
      if (mCount == NB) mFull = 1'b1;
    end else if (mCount > 0) begin
      if (mIdle == TMO - 1) begin
        mCount = 0; mIdle = 0; mTmo = 1'b1;
      end else begin
        mIdle++;
      end
    end
    mOv = setOv | (mOv & !bus.err_clr);
  endtask

  // Advance the model on every edge, then compare all outputs just after the edge.
  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput("block_valid", 128'(bus.block_valid), 128'(mFull));
    checkOutput("byte_count",  128'(bus.byte_count),  128'(mCount));
    checkOutput("block_out",   128'(bus.block_out),   128'(modelBlock()));
    checkOutput("overrun",     128'(bus.overrun),     128'(mOv));
    checkOutput("timeout",     128'(bus.timeout),     128'(mTmo));
  end

  task automatic applyStimulus(input logic [7:0] b, input int hi, input int lo);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    riseCnt      = cycleCnt;
    repeat (hi) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int guard;
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.block_ready = 1'b0;
    bus.err_clr     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_count", 128'(bus.byte_count), 128'd0);
    checkOutput("reset_valid", 128'(bus.block_valid), 128'd0);
    checkOutput("reset_block", 128'(bus.block_out), 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // Full block with the consumer always ready.
    bus.block_ready = 1'b1;
    for (int i = 0; i < NB - 1; i++) applyStimulus(8'(i), 3, 2);
    bus.rx_data  = 8'h0F;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    checkOutput("blk1_valid", 128'(bus.block_valid), 128'd1);
    checkOutput("blk1_data", 128'(bus.block_out), 128'h000102030405060708090A0B0C0D0E0F);
    @(negedge clk);
    checkOutput("blk1_drop", 128'(bus.block_valid), 128'd0);
    checkOutput("blk1_count", 128'(bus.byte_count), 128'd0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Overrun: a 17th byte while the block waits.
    bus.block_ready = 1'b0;
    for (int i = 0; i < NB; i++) applyStimulus(8'(i), 3, 2);
    applyStimulus(8'hAA, 3, 2);
    checkOutput("ovr_flag", 128'(bus.overrun), 128'd1);
    checkOutput("ovr_block", 128'(bus.block_out), 128'h000102030405060708090A0B0C0D0E0F);
    checkOutput("ovr_count", 128'(bus.byte_count), 128'd16);
    bus.block_ready = 1'b1;
    @(negedge clk);
    bus.block_ready = 1'b0;
    checkOutput("ovr_hs_count", 128'(bus.byte_count), 128'd0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checkOutput("ovr_cleared", 128'(bus.overrun), 128'd0);

    // Handshake and new byte on the same cycle.
    for (int i = 0; i < NB; i++) applyStimulus(8'(8'h10 + i), 3, 2);
    checkOutput("blk2_data", 128'(bus.block_out), 128'h101112131415161718191A1B1C1D1E1F);
    bus.rx_data     = 8'h55;
    bus.rx_valid    = 1'b1;
    bus.block_ready = 1'b1;
    @(negedge clk);
    bus.block_ready = 1'b0;
    checkOutput("same_cyc_count", 128'(bus.byte_count), 128'd1);
    checkOutput("same_cyc_byte", 128'(bus.block_out[7:0]), 128'h55);
    checkOutput("same_cyc_ovr", 128'(bus.overrun), 128'd0);
    bus.rx_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Partial block discarded after the idle timeout.
    applyStimulus(8'hA1, 3, 2);
    applyStimulus(8'hA2, 3, 2);
    applyStimulus(8'hA3, 3, 2);
    guard = 0;
    while (bus.timeout !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("tmo_latency", 128'(cycleCnt - riseCnt), 128'd51);
    checkOutput("tmo_count", 128'(bus.byte_count), 128'd0);
    @(negedge clk);
    checkOutput("tmo_one_pulse", 128'(bus.timeout), 128'd0);
    for (int i = 0; i < NB; i++) applyStimulus(8'(8'h20 + i), 3, 2);
    checkOutput("blk3_data", 128'(bus.block_out), 128'h202122232425262728292A2B2C2D2E2F);
    bus.block_ready = 1'b1;
    @(negedge clk);
    bus.block_ready = 1'b0;

    // A byte landing exactly on the expiry cycle keeps the partial block.
    applyStimulus(8'h30, 3, 2);
    guard = riseCnt;
    while (cycleCnt < guard + TMO) @(negedge clk);
    bus.rx_data  = 8'h31;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    checkOutput("expiry_count", 128'(bus.byte_count), 128'd2);
    checkOutput("expiry_no_tmo", 128'(bus.timeout), 128'd0);
    bus.rx_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Reset release with rx_valid already high, then reset mid-block.
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_level_count", 128'(bus.byte_count), 128'd0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) applyStimulus(8'(8'h40 + i), 3, 2);
    checkOutput("mid_count", 128'(bus.byte_count), 128'd10);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_count", 128'(bus.byte_count), 128'd0);
    checkOutput("mid_rst_valid", 128'(bus.block_valid), 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // Random traffic: variable hold and gap lengths, random ready and error clears.
    for (int n = 0; n < 600; n++) begin
      bus.block_ready = ($urandom_range(0, 3) != 0);
      bus.err_clr     = ($urandom_range(0, 9) == 0);
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(1, 40), $urandom_range(1, 20));
    end
    bus.block_ready = 1'b1;
    bus.err_clr     = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
